bus_wait_sequencer: RTL
=======================

// Module: bus_wait_sequencer
// PURPOSE
//  Generates the 6502 phase clock (sys_clk) and the free-running VIA clock from the master clk.
//  Stretches the high phase per decoded device region using a programmable wait count per region, plus an external RDY input.
//  Drives one active-low strobe per region during the high phase.
//  Sits between the address decoder (sel) and the bus devices; replaces hard-coded per-device stretch logic.
// PARAMETERS
//  NREG     4    number of decoded regions (sel/strb_n width)
//  WAIT_W   4    width of each per-region wait count
//  TIMEOUT  255  max extra high-phase clks waiting on ext_rdy before forced release
// PORTS
//  clk           in   1                 master clock; all logic on posedge
//  rst           in   1                 reset, synchronous, active-low
//  sel           in   NREG              decoded region selects, active high; lowest index wins if several are set
//  ext_rdy       in   1                 device ready, high = ready; ignored when no region is selected
//  cfg_we        in   1                 write strobe for the wait-count table
//  cfg_idx       in   $clog2(NREG)      region index for cfg write
//  cfg_wait      in   WAIT_W            wait count written to table[cfg_idx]
//  timeout_clr   in   1                 clears timeout_flag
//  sys_clk       out  1                 CPU phase clock
//  via_clk       out  1                 clk/2, never stretched
//  strb_n        out  NREG              per-region strobe, low during the selected high phase
//  stretching    out  1                 high while the high phase is extended past 1 clk
//  cycle_done    out  1                 1-clk pulse on the clk where sys_clk falls
//  timeout_flag  out  1                 sticky; set when a forced release occurs
// BEHAVIOUR
//  - Reset (rst=0 at posedge) sets: state=LOW, sys_clk=0, via_clk=0, strb_n=all 1, stretching=0, cycle_done=0,
//    timeout_flag=0, all table entries=0, wcnt=0, tcnt=0. Reset mid-stretch aborts the cycle at that edge.
//  - via_clk toggles on every clk, independent of the FSM.
//  - FSM states: LOW and HIGH. sys_clk is registered and equals (state==HIGH).
//  - LOW always lasts 1 clk. On the exiting edge:
//      state<=HIGH; reg_idx<=lowest set bit of sel.
//      If sel!=0: hit<=1, wcnt<=table[reg_idx], strb_n[reg_idx]<=0.
//      If sel==0: hit<=0, wcnt<=0.
//      tcnt<=0.
//  - On each clk in HIGH:
//      wcnt!=0: wcnt<=wcnt-1; stay in HIGH.
//      wcnt==0 and (!hit or ext_rdy): release.
//      wcnt==0, hit, !ext_rdy, tcnt<TIMEOUT: tcnt<=tcnt+1; stay in HIGH.
//      wcnt==0, hit, !ext_rdy, tcnt==TIMEOUT: release; timeout_flag<=1.
//  - Release edge: state<=LOW, sys_clk<=0, strb_n<=all 1, cycle_done<=1 for exactly 1 clk.
//  - Timing:
//      unstretched period = 2 clk (50% duty);
//      high-phase length = 1+W clk when ext_rdy stays high;
//      high phase capped at 1+W+TIMEOUT clk.
//  - stretching=1 on every HIGH clk after the first one; 0 in LOW.
//  - Table writes take effect at any edge (cfg_we=1). An in-flight wcnt is unaffected; the new value is used at the next LOW->HIGH capture.
//  - timeout_flag: timeout_clr clears it; a set and a clear on the same edge leave it set.
//  - sel and ext_rdy are sampled only as described above; sel changes during HIGH are ignored.
//  - Width rules: wcnt is WAIT_W bits; tcnt is $clog2(TIMEOUT+1) bits and saturates at TIMEOUT; no wrap-around.
// TESTING
//  1 Reset, then sel=0: sys_clk 0,1,0,1 (period 2); via_clk period 2; strb_n=4'b1111; cycle_done every 2nd clk.
//  2 table[2]=3, sel=4'b0100, ext_rdy=1: sys_clk high 4 clk; strb_n=4'b1011 for exactly those 4 clk;
//    stretching high on the last 3; one cycle_done pulse.
//  3 table[1]=1, table[2]=5, sel=4'b0110: region 1 wins; high 2 clk; strb_n=4'b1101.
//  4 TIMEOUT=8, table[0]=0, sel=4'b0001, ext_rdy=0: high 9 clk, then forced low; timeout_flag=1;
//    timeout_clr=1 clears it; set+clr on the same clk -> stays 1.
//  5 table[0]=2, region 0 active; write table[0]=7 on 2nd high clk: current high=3 clk, next region-0 access high=8 clk.
//  6 rst=0 during a 6-clk stretch: next edge sys_clk=0, strb_n=4'b1111, table all 0; after release, period 2.

Source files
------------

// File: rtl/bus_wait_sequencer.sv
// Purpose: generates the 6502 phase clock and the VIA clock, stretching the high phase per decoded region.
// Latency: sel and table capture on the LOW->HIGH edge; the high phase lasts 1+W clk, plus ext_rdy waits up to TIMEOUT clk.
// Backpressure: ext_rdy low holds the high phase after the wait count expires, until the timeout forces a release.
module bus_wait_sequencer #(
    parameter int NREG    = 4,
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREG-1:0]         sel_i,
    input  logic                    ext_rdy_i,
    input  logic                    cfg_we_i,
    input  logic [$clog2(NREG)-1:0] cfg_idx_i,
    input  logic [WAIT_W-1:0]       cfg_wait_i,
    input  logic                    timeout_clr_i,
    output logic                    sys_clk_o,
    output logic                    via_clk_o,
    output logic [NREG-1:0]         strb_n_o,
    output logic                    stretching_o,
    output logic                    cycle_done_o,
    output logic                    timeout_flag_o
);

    localparam int IDX_W  = $clog2(NREG);
    localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TCNT_W-1:0] TMAX = TCNT_W'(TIMEOUT);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   table_q [NREG];
    logic                hit_q, hit_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [NREG-1:0]     strb_n_q, strb_n_d;
    logic                stretching_q, stretching_d;
    logic                cycle_done_q, cycle_done_d;
    logic                timeout_flag_q, timeout_flag_d;
    logic                via_clk_q;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_any;
    logic                forced_rel;

    assign sel_any = |sel_i;

    // Priority encoder: the lowest-numbered active select owns the cycle.
    always_comb begin
        sel_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (sel_i[i]) begin
                sel_idx = i[IDX_W-1:0];
            end
        end
    end

    // Next-state logic: LOW is always one clk; HIGH counts down the wait, then waits on ext_rdy with a cap.
    always_comb begin
        state_d      = state_q;
        hit_d        = hit_q;
        wcnt_d       = wcnt_q;
        tcnt_d       = tcnt_q;
        strb_n_d     = strb_n_q;
        stretching_d = 1'b0;
        cycle_done_d = 1'b0;
        forced_rel   = 1'b0;
        case (state_q)
            ST_LOW: begin
                state_d  = ST_HIGH;
                tcnt_d   = '0;
                strb_n_d = '1;
                if (sel_any) begin
                    hit_d             = 1'b1;
                    wcnt_d            = table_q[sel_idx];
                    strb_n_d[sel_idx] = 1'b0;
                end else begin
                    hit_d  = 1'b0;
                    wcnt_d = '0;
                end
            end
            ST_HIGH: begin
                if (wcnt_q != '0) begin
                    wcnt_d       = wcnt_q - WAIT_W'(1);
                    stretching_d = 1'b1;
                end else if (!hit_q || ext_rdy_i) begin
                    state_d      = ST_LOW;
                    strb_n_d     = '1;
                    cycle_done_d = 1'b1;
                end else if (tcnt_q < TMAX) begin
                    tcnt_d       = tcnt_q + TCNT_W'(1);
                    stretching_d = 1'b1;
                end else begin
                    state_d      = ST_LOW;
                    strb_n_d     = '1;
                    cycle_done_d = 1'b1;
                    forced_rel   = 1'b1;
                end
            end
            default: begin
                state_d  = ST_LOW;
                strb_n_d = '1;
            end
        endcase
        // A forced release outranks a clear on the same edge so the event is never lost.
        if (forced_rel) begin
            timeout_flag_d = 1'b1;
        end else if (timeout_clr_i) begin
            timeout_flag_d = 1'b0;
        end else begin
            timeout_flag_d = timeout_flag_q;
        end
    end

    // State and cycle registers; reset aborts any cycle in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_LOW;
            hit_q          <= 1'b0;
            wcnt_q         <= '0;
            tcnt_q         <= '0;
            strb_n_q       <= '1;
            stretching_q   <= 1'b0;
            cycle_done_q   <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hit_q          <= hit_d;
            wcnt_q         <= wcnt_d;
            tcnt_q         <= tcnt_d;
            strb_n_q       <= strb_n_d;
            stretching_q   <= stretching_d;
            cycle_done_q   <= cycle_done_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    // Wait-count table; new values only matter at the next LOW->HIGH capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we_i) begin
            table_q[cfg_idx_i] <= cfg_wait_i;
        end
    end

    // VIA clock free-runs at clk/2 and never sees the stretch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            via_clk_q <= 1'b0;
        end else begin
            via_clk_q <= ~via_clk_q;
        end
    end

    assign sys_clk_o      = (state_q == ST_HIGH);
    assign via_clk_o      = via_clk_q;
    assign strb_n_o       = strb_n_q;
    assign stretching_o   = stretching_q;
    assign cycle_done_o   = cycle_done_q;
    assign timeout_flag_o = timeout_flag_q;

endmodule
